baud_rate_generator: RTL and testbench

//  Parametrised successor to the UART baud tick source. A phase accumulator

---
 rtl/baud_rate_generator.sv | 145 ++++++++++++++
 tb/tb_baud_rate_generator.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_rate_generator.sv
// baud_rate_generator: phase-accumulator UART tick source with oversampling and 1x bit strobes.
// Optional feature macro BAUD_CUSTOM_INC_EN adds a runtime-loadable custom increment.

module baud_rate_generator #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned ACC_W       = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [2:0]                    baud_select,
`ifdef BAUD_CUSTOM_INC_EN
    input  logic                          inc_load,
    input  logic [ACC_W-1:0]              inc_value,
`endif
    output logic                          sample_ENABLE,
    output logic                          tx_ENABLE,
    output logic [$clog2(OVERSAMPLE)-1:0] sample_phase
);

    localparam int unsigned PH_W    = $clog2(OVERSAMPLE);
    localparam int unsigned N_RATES = 8;

    function automatic longint unsigned baud_of(input int unsigned s);
        case (s)
            0:       return 64'd300;
            1:       return 64'd1200;
            2:       return 64'd4800;
            3:       return 64'd9600;
            4:       return 64'd19200;
            5:       return 64'd38400;
            6:       return 64'd57600;
            default: return 64'd115200;
        endcase
    endfunction

    // Rounded phase increment for one preset rate.
    function automatic longint unsigned inc_of(input int unsigned s);
        longint unsigned num;
        num = baud_of(s) * 64'(OVERSAMPLE) * (64'd1 << ACC_W);
        return (num + 64'(CLK_FREQ_HZ / 2)) / 64'(CLK_FREQ_HZ);
    endfunction

    localparam longint unsigned INC_LIMIT = 64'd1 << (ACC_W - 1);

    localparam logic [ACC_W-1:0] INC_TAB [N_RATES] = '{
        ACC_W'(inc_of(0)), ACC_W'(inc_of(1)), ACC_W'(inc_of(2)), ACC_W'(inc_of(3)),
        ACC_W'(inc_of(4)), ACC_W'(inc_of(5)), ACC_W'(inc_of(6)), ACC_W'(inc_of(7))
    };

    // Elaboration guards on the parameter set and the derived increment table.
    generate
        if (OVERSAMPLE < 4 || OVERSAMPLE > 64 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_ovs
            $fatal(1, "baud_rate_generator: OVERSAMPLE must be a power of 2 in 4..64");
        end
        if (ACC_W < 8 || ACC_W > 40) begin : g_bad_acc_w
            $fatal(1, "baud_rate_generator: ACC_W must be in 8..40");
        end
        for (genvar i = 0; i < N_RATES; i++) begin : g_inc_chk
            if (inc_of(i) == 64'd0 || inc_of(i) >= INC_LIMIT) begin : g_bad_inc
                $fatal(1, "baud_rate_generator: increment for rate %0d out of range", i);
            end
        end
    endgenerate

    logic [2:0]       sel_q, sel_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [PH_W-1:0]  ovs_q, ovs_d;
    logic             sample_d;
    logic             tx_d;
    logic [ACC_W-1:0] inc_sel;
    logic [ACC_W:0]   sum;
    logic             restart;
`ifdef BAUD_CUSTOM_INC_EN
    logic             custom_q, custom_d;
    logic [ACC_W-1:0] cinc_q, cinc_d;
`endif

    // Next-state: restart beats accumulation; enable gates the add and the strobes.
    always_comb begin
        sel_d    = sel_q;
        acc_d    = acc_q;
        ovs_d    = ovs_q;
        sample_d = 1'b0;
        tx_d     = 1'b0;
        inc_sel  = INC_TAB[sel_q];
        restart  = (baud_select != sel_q);
`ifdef BAUD_CUSTOM_INC_EN
        custom_d = custom_q;
        cinc_d   = cinc_q;
        if (custom_q) begin
            inc_sel = cinc_q;
        end
        if (inc_load && (inc_value != '0)) begin
            cinc_d   = inc_value;
            custom_d = 1'b1;
            restart  = 1'b1;
        end else if (restart) begin
            custom_d = 1'b0;
        end
`endif
        sum = {1'b0, acc_q} + {1'b0, inc_sel};

        if (restart) begin
            sel_d = baud_select;
            acc_d = '0;
            ovs_d = '0;
        end else if (enable) begin
            acc_d = sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
                sample_d = 1'b1;
                tx_d     = (ovs_q == PH_W'(OVERSAMPLE - 1));
                ovs_d    = ovs_q + PH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_q         <= baud_select;
            acc_q         <= '0;
            ovs_q         <= '0;
            sample_ENABLE <= 1'b0;
            tx_ENABLE     <= 1'b0;
`ifdef BAUD_CUSTOM_INC_EN
            custom_q      <= 1'b0;
            cinc_q        <= '0;
`endif
        end else begin
            sel_q         <= sel_d;
            acc_q         <= acc_d;
            ovs_q         <= ovs_d;
            sample_ENABLE <= sample_d;
            tx_ENABLE     <= tx_d;
`ifdef BAUD_CUSTOM_INC_EN
            custom_q      <= custom_d;
            cinc_q        <= cinc_d;
`endif
        end
    end

    assign sample_phase = ovs_q;

endmodule

// File: tb/tb_baud_rate_generator.sv
// Self-checking bench for baud_rate_generator: rate table vectors, enable/reset corner
// sequences and a randomized run against an arithmetic strobe-count model.

module tb_baud_rate_generator;

    localparam int unsigned ACC_W  = 24;
    localparam int unsigned OVS    = 16;
    localparam int unsigned CLK_HZ = 100_000_000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [2:0] baud_select = 3'd3;
`ifdef BAUD_CUSTOM_INC_EN
    logic             inc_load = 1'b0;
    logic [ACC_W-1:0] inc_value = '0;
`endif
    logic       sample_ENABLE;
    logic       tx_ENABLE;
    logic [3:0] sample_phase;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    baud_rate_generator #(
        .CLK_FREQ_HZ(CLK_HZ),
        .OVERSAMPLE (OVS),
        .ACC_W      (ACC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .baud_select  (baud_select),
`ifdef BAUD_CUSTOM_INC_EN
        .inc_load     (inc_load),
        .inc_value    (inc_value),
`endif
        .sample_ENABLE(sample_ENABLE),
        .tx_ENABLE    (tx_ENABLE),
        .sample_phase (sample_phase)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint unsigned act,
                               input longint unsigned lo, input longint unsigned hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic longint unsigned baud_of(input int unsigned s);
        longint unsigned rates [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
        return rates[s];
    endfunction

    function automatic longint unsigned inc_of(input int unsigned s);
        longint unsigned num;
        num = baud_of(s) * 64'(OVS) * (64'd1 << ACC_W);
        return (num + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
    endfunction

    // Count negedges until a sample strobe is seen; tx must never fire on its own.
    task automatic wait_strobe(input int limit, input string name, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            check({name, "_tx_alone"}, 64'(tx_ENABLE & ~sample_ENABLE), 64'd0);
        end while (!sample_ENABLE && cnt < limit);
        if (!sample_ENABLE) begin
            checks++;
            errors++;
            $display("FAIL %s: no strobe within %0d cycles", name, cnt);
        end
    endtask

    // Model: strobe count since restart is floor(n*INC / 2^ACC_W) for n enabled cycles.
    int unsigned     m_sel;
    longint unsigned m_n;

    task automatic model_step(input logic r, input logic e, input logic [2:0] s,
                              output logic es, output logic et, output logic [3:0] ep);
        longint unsigned inc, k0, k1;
        if (!r || int'(s) != int'(m_sel)) begin
            m_sel = int'(s);
            m_n   = 0;
            es = 1'b0; et = 1'b0; ep = 4'd0;
        end else begin
            inc = inc_of(m_sel);
            k0  = (m_n * inc) >> ACC_W;
            if (e) m_n++;
            k1  = (m_n * inc) >> ACC_W;
            es  = e && (k1 != k0);
            et  = es && (k1 % 64'(OVS) == 0);
            ep  = 4'(k1 % 64'(OVS));
        end
    endtask

    typedef struct {
        logic [2:0] sel;
        int         first;
        int         lo;
        int         hi;
        int         n;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int              cnt;
        int              k;
        longint unsigned inc6, k_now, n_next, n_due;
        logic            es, et;
        logic [3:0]      ep;

        // {select, cycles from change to first strobe, spacing lo, spacing hi, spacings measured}
        vecs[0] = '{3'd7, 56,    54,    55,    20};
        vecs[1] = '{3'd0, 20843, 20841, 20842, 1};
        vecs[2] = '{3'd7, 56,    54,    55,    20};
        vecs[3] = '{3'd6, 110,   108,   109,   10};
        vecs[4] = '{3'd5, 164,   162,   163,   10};
        vecs[5] = '{3'd4, 327,   325,   326,   5};
        vecs[6] = '{3'd2, 1304,  1302,  1303,  2};
        vecs[7] = '{3'd1, 5210,  5208,  5209,  0};
        vecs[8] = '{3'd3, 653,   651,   652,   3};

        // Reset hold: everything quiet, then first strobe at rate 011.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_sample", 64'(sample_ENABLE), 64'd0);
            check("reset_tx", 64'(tx_ENABLE), 64'd0);
            check("reset_phase", 64'(sample_phase), 64'd0);
        end
        reset = 1'b1;
        wait_strobe(700, "rst_first", cnt);
        check("rst_first_delay", 64'(cnt), 64'd652);
        check("rst_first_phase", 64'(sample_phase), 64'd1);

        // Table: rate change, dead cycle, first strobe latency, spacing and phase sequence.
        for (int i = 0; i < 9; i++) begin
            baud_select = vecs[i].sel;
            @(negedge clk);
            check($sformatf("dead_strobe_sel%0d", vecs[i].sel), 64'(sample_ENABLE | tx_ENABLE), 64'd0);
            check($sformatf("dead_phase_sel%0d", vecs[i].sel), 64'(sample_phase), 64'd0);
            wait_strobe(vecs[i].first + 10, $sformatf("first_sel%0d", vecs[i].sel), cnt);
            check($sformatf("first_delay_sel%0d", vecs[i].sel), 64'(cnt + 1), 64'(vecs[i].first));
            k = 1;
            check($sformatf("first_phase_sel%0d", vecs[i].sel), 64'(sample_phase), 64'd1);
            for (int j = 0; j < vecs[i].n; j++) begin
                wait_strobe(vecs[i].hi + 5, $sformatf("gap_sel%0d", vecs[i].sel), cnt);
                check_range($sformatf("spacing_sel%0d", vecs[i].sel), 64'(cnt),
                            64'(vecs[i].lo), 64'(vecs[i].hi));
                k++;
                check($sformatf("phase_sel%0d", vecs[i].sel), 64'(sample_phase), 64'(k % OVS));
                check($sformatf("tx_sel%0d", vecs[i].sel), 64'(tx_ENABLE), 64'(k % OVS == 0));
            end
        end

        // Enable freeze mid-bit at rate 110, then resume on the remaining distance.
        inc6 = inc_of(6);
        baud_select = 3'd6;
        @(negedge clk);
        repeat (200) @(negedge clk);
        enable = 1'b0;
        k_now = (64'd200 * inc6) >> ACC_W;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            check("frozen_strobe", 64'(sample_ENABLE | tx_ENABLE), 64'd0);
            check("frozen_phase", 64'(sample_phase), k_now % 64'(OVS));
        end
        enable = 1'b1;
        n_next = (((k_now + 1) << ACC_W) + inc6 - 1) / inc6;
        wait_strobe(300, "resume", cnt);
        check("resume_delay", 64'(cnt), n_next - 64'd200);
        check("resume_phase", 64'(sample_phase), (k_now + 1) % 64'(OVS));

        // Reset asserted on the cycle a carry is due: no strobe, outputs cleared.
        n_due = (((k_now + 2) << ACC_W) + inc6 - 1) / inc6;
        repeat (int'(n_due - n_next - 1)) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("carry_rst_sample", 64'(sample_ENABLE), 64'd0);
        check("carry_rst_tx", 64'(tx_ENABLE), 64'd0);
        check("carry_rst_phase", 64'(sample_phase), 64'd0);
        reset = 1'b1;
        wait_strobe(200, "carry_rst_first", cnt);
        check("carry_rst_first_delay", 64'(cnt), 64'd109);

        // Randomized run against the strobe-count model.
        reset = 1'b0;
        enable = 1'b1;
        baud_select = 3'($urandom_range(4, 7));
        @(negedge clk);
        model_step(reset, enable, baud_select, es, et, ep);
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 399) == 0) baud_select = 3'($urandom_range(4, 7));
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            reset = ($urandom_range(0, 1499) != 0);
            @(negedge clk);
            model_step(reset, enable, baud_select, es, et, ep);
            check("rand_sample", 64'(sample_ENABLE), 64'(es));
            check("rand_tx", 64'(tx_ENABLE), 64'(et));
            check("rand_phase", 64'(sample_phase), 64'(ep));
        end
        reset = 1'b1;
        enable = 1'b1;

`ifdef BAUD_CUSTOM_INC_EN
        // Custom increment: 16/17 spacing, zero load ignored, rate change returns to presets.
        inc_value = ACC_W'(1_000_000);
        inc_load = 1'b1;
        @(negedge clk);
        inc_load = 1'b0;
        check("cust_dead", 64'(sample_ENABLE), 64'd0);
        wait_strobe(40, "cust_first", cnt);
        check("cust_first_delay", 64'(cnt + 1), 64'd18);
        k = 1;
        for (int j = 0; j < 4; j++) begin
            wait_strobe(30, "cust_gap", cnt);
            check_range("cust_spacing", 64'(cnt), 64'd16, 64'd17);
            k++;
        end
        inc_value = '0;
        inc_load = 1'b1;
        @(negedge clk);
        inc_load = 1'b0;
        cnt = 1;
        if (!sample_ENABLE) begin
            wait_strobe(30, "cust_zero_gap", k_now[31:0]);
            cnt += int'(k_now[31:0]);
        end
        check_range("cust_zero_spacing", 64'(cnt), 64'd16, 64'd17);
        check("cust_zero_phase", 64'(sample_phase), 64'((k + 1) % OVS));
        baud_select = (baud_select == 3'd7) ? 3'd6 : 3'd7;
        @(negedge clk);
        check("cust_exit_dead", 64'(sample_ENABLE), 64'd0);
        wait_strobe(150, "cust_exit_first", cnt);
        check("cust_exit_delay", 64'(cnt + 1), (baud_select == 3'd7) ? 64'd56 : 64'd110);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
